// File: rtl/fpu_sched_pkg.sv
// rtl/fpu_sched_pkg.sv - opcodes, scheduler state and opcode legality for fpu_sched.
package fpu_sched_pkg;

    localparam logic [3:0] FPUOP_FADD   = 4'b0000;
    localparam logic [3:0] FPUOP_FSUB   = 4'b0001;
    localparam logic [3:0] FPUOP_FMUL   = 4'b0010;
    localparam logic [3:0] FPUOP_FDIV   = 4'b0011;
    localparam logic [3:0] FPUOP_FSQRT  = 4'b0100;
    localparam logic [3:0] FPUOP_FSGNJ  = 4'b0101;
    localparam logic [3:0] FPUOP_FSGNJN = 4'b0110;
    localparam logic [3:0] FPUOP_FSGNJX = 4'b0111;
    localparam logic [3:0] FPUOP_FEQ    = 4'b1000;
    localparam logic [3:0] FPUOP_FLT    = 4'b1001;
    localparam logic [3:0] FPUOP_FLE    = 4'b1010;
    localparam logic [3:0] FPUOP_FCVTWS = 4'b1011;
    localparam logic [3:0] FPUOP_FCVTSW = 4'b1100;
    localparam logic [3:0] FPUOP_IDLE   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= FPUOP_FCVTSW;
    endfunction

endpackage

// File: rtl/fpu_sched_rr_arb2.sv
// rtl/fpu_sched_rr_arb2.sv - two-way round-robin arbiter, pointer moves past the winner on accept.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic ptr;

    // A lone requester always wins; contention is settled by the pointer.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= ~gnt[1];
        end
    end

endmodule

// File: rtl/fpu_sched.sv
// rtl/fpu_sched.sv - two-requester round-robin scheduler for the shared multi-cycle FPU.
// Optional perf counters perf_ops/perf_busy are built when FPU_SCHED_PERF_EN is defined.
module fpu_sched
    import fpu_sched_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][3:0]       req_op,
    input  logic [1:0][31:0]      req_src0,
    input  logic [1:0][31:0]      req_src1,
    input  logic [1:0][TAG_W-1:0] req_tag,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic                  rsp_err,
`ifdef FPU_SCHED_PERF_EN
    output logic [31:0]           perf_ops,
    output logic [31:0]           perf_busy,
`endif
    output logic [3:0]            fpu_op,
    output logic [31:0]           fpu_src0,
    output logic [31:0]           fpu_src1,
    input  logic [31:0]           fpu_result,
    input  logic                  fpu_fin
);

    sched_state_e state;
    logic         idx_q;
    logic [1:0]   gnt;
    logic         accept;
    logic         hs_idx;
    logic [3:0]   hs_op;
    logic         rsp_hs;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .accept (accept),
        .gnt    (gnt)
    );

    assign accept    = (state == IDLE) && !rst && (gnt != 2'b00);
    assign req_ready = (state == IDLE && !rst) ? gnt : 2'b00;
    assign hs_idx    = gnt[1];
    assign hs_op     = req_op[hs_idx];
    assign rsp_valid = (state == RESP) ? (idx_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_hs    = (state == RESP) && rsp_ready[idx_q];

    // fpu_op doubles as the opcode capture register, so it is idle outside EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx_q    <= 1'b0;
            fpu_op   <= FPUOP_IDLE;
            fpu_src0 <= '0;
            fpu_src1 <= '0;
            rsp_data <= '0;
            rsp_tag  <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx_q   <= hs_idx;
                        rsp_tag <= req_tag[hs_idx];
                        if (is_legal_op(hs_op)) begin
                            fpu_op   <= hs_op;
                            fpu_src0 <= req_src0[hs_idx];
                            fpu_src1 <= req_src1[hs_idx];
                            rsp_err  <= 1'b0;
                            state    <= EXEC;
                        end else begin
                            rsp_err  <= 1'b1;
                            rsp_data <= '0;
                            state    <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (fpu_fin) begin
                        rsp_data <= fpu_result;
                        fpu_op   <= FPUOP_IDLE;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FPU_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops  <= '0;
            perf_busy <= '0;
        end else begin
            if (rsp_hs) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if (state == EXEC) begin
                perf_busy <= perf_busy + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_sched.sv
// tb/tb_fpu_sched.sv - directed self-checking bench for fpu_sched with a behavioural FPU model.
module tb_fpu_sched;
    import fpu_sched_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][3:0]  req_op;
    logic [1:0][31:0] req_src0;
    logic [1:0][31:0] req_src1;
    logic [1:0][4:0]  req_tag;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [31:0]      rsp_data;
    logic [4:0]       rsp_tag;
    logic             rsp_err;
    logic [3:0]       fpu_op;
    logic [31:0]      fpu_src0;
    logic [31:0]      fpu_src1;
    logic [31:0]      fpu_result;
    logic             fpu_fin;
`ifdef FPU_SCHED_PERF_EN
    logic [31:0]      perf_ops;
    logic [31:0]      perf_busy;
`endif

    int cyc        = 0;
    int fcnt       = 0;
    int fpu_active = 0;
    int checks     = 0;
    int errors     = 0;

    fpu_sched #(.TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_src0   (req_src0),
        .req_src1   (req_src1),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err),
`ifdef FPU_SCHED_PERF_EN
        .perf_ops   (perf_ops),
        .perf_busy  (perf_busy),
`endif
        .fpu_op     (fpu_op),
        .fpu_src0   (fpu_src0),
        .fpu_src1   (fpu_src1),
        .fpu_result (fpu_result),
        .fpu_fin    (fpu_fin)
    );

    always #5 clk = ~clk;

    // FPU model: counts busy cycles, fin is combinational once the op latency is reached.
    function automatic int fpu_lat(input logic [3:0] op);
        case (op)
            FPUOP_FADD, FPUOP_FSUB:     return 3;
            FPUOP_FMUL:                 return 2;
            FPUOP_FDIV:                 return 10;
            FPUOP_FSQRT:                return 7;
            FPUOP_FCVTWS, FPUOP_FCVTSW: return 1;
            default:                    return 0;
        endcase
    endfunction

    function automatic logic [31:0] fpu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'hBAD0_0000 ^ {28'h0, op};
        case (op)
            FPUOP_FADD:   if (a == 32'h3F80_0000 && b == 32'h4000_0000) r = 32'h4040_0000;
            FPUOP_FSUB:   if (a == 32'h4040_0000 && b == 32'h3F80_0000) r = 32'h4000_0000;
            FPUOP_FMUL:   if (a == 32'h4000_0000 && b == 32'h4040_0000) r = 32'h40C0_0000;
            FPUOP_FDIV:   if (a == 32'h3F80_0000 && b == 32'h4080_0000) r = 32'h3E80_0000;
            FPUOP_FSQRT:  if (a == 32'h4080_0000) r = 32'h4000_0000;
            FPUOP_FEQ:    r = {31'h0, a == b};
            FPUOP_FCVTSW: if (a == 32'd5) r = 32'h40A0_0000;
            default:      r = 32'hBAD0_0000 ^ {28'h0, op};
        endcase
        return r;
    endfunction

    assign fpu_fin    = (fpu_op != FPUOP_IDLE) && (fcnt == fpu_lat(fpu_op));
    assign fpu_result = fpu_model(fpu_op, fpu_src0, fpu_src1);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            fcnt <= 0;
        end else if (fpu_op != FPUOP_IDLE) begin
            fcnt <= fpu_fin ? 0 : fcnt + 1;
        end
        if (fpu_op != FPUOP_IDLE) begin
            fpu_active <= fpu_active + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request and wait for its handshake; returns one negedge later with valid dropped.
    task automatic issue(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output int t);
        bit got;
        got = 1'b0;
        t   = 0;
        req_valid[r] = 1'b1;
        req_op[r]    = op;
        req_src0[r]  = a;
        req_src1[r]  = b;
        req_tag[r]   = tag;
        for (int i = 0; i < 60 && !got; i++) begin
            #1;
            if (req_ready[r]) begin
                got = 1'b1;
                t   = cyc;
            end
            @(negedge clk);
        end
        req_valid[r] = 1'b0;
        check("accept", {31'h0, got}, 32'd1);
    endtask

    task automatic wait_rsp(input int r, output int t);
        bit got;
        got = 1'b0;
        t   = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            #1;
            if (rsp_valid != 2'b00) begin
                got = 1'b1;
                t   = cyc;
            end else begin
                @(negedge clk);
            end
        end
        check("rsp_seen", {31'h0, got}, 32'd1);
        check("rsp_onehot", {30'h0, rsp_valid}, (r == 1) ? 32'd2 : 32'd1);
    endtask

    task automatic run_op(input string nm, input int r, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp_d,
                          input int exp_lat, input logic exp_err);
        int t0, t1;
        issue(r, op, a, b, tag, t0);
        wait_rsp(r, t1);
        check({nm, "_lat"}, t1 - t0, exp_lat);
        check({nm, "_data"}, rsp_data, exp_d);
        check({nm, "_tag"}, {27'h0, rsp_tag}, {27'h0, tag});
        check({nm, "_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
        check({nm, "_fpuop_idle"}, {28'h0, fpu_op}, {28'h0, FPUOP_IDLE});
        @(negedge clk);
        rsp_ready[r] = 1'b1;
        @(negedge clk);
        rsp_ready[r] = 1'b0;
        #1;
        check({nm, "_rsp_done"}, {30'h0, rsp_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_req_ready"}, {30'h0, req_ready}, 32'd0);
        check({nm, "_rsp_valid"}, {30'h0, rsp_valid}, 32'd0);
        check({nm, "_rsp_data"}, rsp_data, 32'd0);
        check({nm, "_rsp_tag"}, {27'h0, rsp_tag}, 32'd0);
        check({nm, "_rsp_err"}, {31'h0, rsp_err}, 32'd0);
        check({nm, "_fpu_op"}, {28'h0, fpu_op}, {28'h0, FPUOP_IDLE});
        check({nm, "_fpu_src0"}, fpu_src0, 32'd0);
        check({nm, "_fpu_src1"}, fpu_src1, 32'd0);
`ifdef FPU_SCHED_PERF_EN
        check({nm, "_perf_ops"}, perf_ops, 32'd0);
        check({nm, "_perf_busy"}, perf_busy, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, k, nrsp, a0;
        int order [5] = '{0, 1, 0, 1, 0};

        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_src0  = '0;
        req_src1  = '0;
        req_tag   = '0;
        rsp_ready = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("reset");

        // Single fadd from requester 0.
        @(negedge clk);
        run_op("fadd", 0, FPUOP_FADD, 32'h3F80_0000, 32'h4000_0000, 5'd3, 32'h4040_0000, 5, 1'b0);

        // Both requesters valid through reset, then held: grants alternate from requester 0.
        @(negedge clk);
        rst         = 1'b1;
        req_valid   = 2'b11;
        req_op[0]   = FPUOP_FMUL;
        req_src0[0] = 32'h4000_0000;
        req_src1[0] = 32'h4040_0000;
        req_tag[0]  = 5'd1;
        req_op[1]   = FPUOP_FDIV;
        req_src0[1] = 32'h3F80_0000;
        req_src1[1] = 32'h4080_0000;
        req_tag[1]  = 5'd2;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready_gated", {30'h0, req_ready}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        rsp_ready = 2'b11;
        k    = 0;
        nrsp = 0;
        for (int i = 0; i < 300 && nrsp < 5; i++) begin
            if (k == 5) req_valid = 2'b00;
            #1;
            if (req_ready != 2'b00 && k < 5) begin
                check("rr_grant", {30'h0, req_ready}, (order[k] == 1) ? 32'd2 : 32'd1);
                k++;
            end
            if (rsp_valid == 2'b01) begin
                check("rr_rsp0_data", rsp_data, 32'h40C0_0000);
                check("rr_rsp0_tag", {27'h0, rsp_tag}, 32'd1);
                nrsp++;
            end else if (rsp_valid == 2'b10) begin
                check("rr_rsp1_data", rsp_data, 32'h3E80_0000);
                check("rr_rsp1_tag", {27'h0, rsp_tag}, 32'd2);
                nrsp++;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        check("rr_grants", k, 5);
        check("rr_rsps", nrsp, 5);

        // Single-cycle compare, then the longest op.
        @(negedge clk);
        run_op("feq", 1, FPUOP_FEQ, 32'h4000_0000, 32'h4000_0000, 5'd4, 32'd1, 2, 1'b0);
        run_op("fdiv", 1, FPUOP_FDIV, 32'h3F80_0000, 32'h4080_0000, 5'd5, 32'h3E80_0000, 12, 1'b0);

        // Illegal opcode: error response, FPU never leaves idle.
        a0 = fpu_active;
        run_op("illegal", 0, 4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 32'd0, 1, 1'b1);
        check("illegal_fpu_quiet", fpu_active - a0, 0);

        // Response backpressure with requester 1 waiting.
        @(negedge clk);
        issue(0, FPUOP_FSUB, 32'h4040_0000, 32'h3F80_0000, 5'd9, t0);
        req_valid[1] = 1'b1;
        req_op[1]    = FPUOP_FCVTSW;
        req_src0[1]  = 32'd5;
        req_src1[1]  = 32'd0;
        req_tag[1]   = 5'd10;
        wait_rsp(0, t1);
        check("hold_lat", t1 - t0, 5);
        for (int i = 0; i < 20; i++) begin
            check("hold_valid", {30'h0, rsp_valid}, 32'd1);
            check("hold_data", rsp_data, 32'h4000_0000);
            check("hold_tag", {27'h0, rsp_tag}, 32'd9);
            check("hold_ready", {30'h0, req_ready}, 32'd0);
            @(negedge clk);
            #1;
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        #1;
        check("release_valid", {30'h0, rsp_valid}, 32'd0);
        check("release_grant1", {30'h0, req_ready}, 32'd2);
        t0 = cyc;
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_rsp(1, t1);
        check("fcvt_lat", t1 - t0, 3);
        check("fcvt_data", rsp_data, 32'h40A0_0000);
        check("fcvt_tag", {27'h0, rsp_tag}, 32'd10);
        check("fcvt_err", {31'h0, rsp_err}, 32'd0);
        @(negedge clk);
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        rsp_ready[1] = 1'b0;

        // Reset in the fourth EXEC cycle of an fsqrt aborts it.
        issue(0, FPUOP_FSQRT, 32'h4080_0000, 32'h0000_0000, 5'd11, t0);
        repeat (3) @(negedge clk);
        #1;
        check("sqrt_in_exec", {28'h0, fpu_op}, {28'h0, FPUOP_FSQRT});
        check("sqrt_no_rsp", {30'h0, rsp_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        nrsp = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid != 2'b00) nrsp++;
        end
        check("abort_no_rsp", nrsp, 0);

        // Recovery after the abort.
        @(negedge clk);
        run_op("fadd2", 0, FPUOP_FADD, 32'h3F80_0000, 32'h4000_0000, 5'd12, 32'h4040_0000, 5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_sched.md
Name: fpu_sched

Overview:
- Two-requester round-robin scheduler in front of the shared multi-cycle FPU.
- Accepts operations over valid/ready and registers the operands.
- Holds `fpu_op`/`fpu_src0`/`fpu_src1` stable until `fpu_fin`, then returns the result with the request's tag to the originating requester.
- Drives the FPU with the idle opcode whenever no operation is in flight, so the FPU's internal counter never starts spuriously.

Parameters:
- `TAG_W`, 5, width of the per-request tag returned with the response.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset. The top level ties the FPU's `rstn` to `~rst`.
- `req_valid`  in  2  per-requester request valid.
- `req_ready`  out  2  per-requester accept.
- `req_op`  in  2x4  FPU opcode per requester (0000 fadd … 1100 fcvt.s.w).
- `req_src0`, `req_src1`  in  2x32  operands.
- `req_tag`  in  2xTAG_W  tag.
- `rsp_valid`  out  2  response valid; one-hot or zero.
- `rsp_ready`  in  2  response accept.
- `rsp_data`  out  32  result.
- `rsp_tag`  out  TAG_W  tag of the completed request.
- `rsp_err`  out  1  illegal opcode (1101–1111).
- `fpu_op`  out  4  to FPU `fpuop`.
- `fpu_src0`, `fpu_src1`  out  32  to FPU `src0`/`src1`.
- `fpu_result`  in  32  FPU result.
- `fpu_fin`  in  1  FPU `fin`.

Behaviour:
- States are IDLE, EXEC, RESP. Reset forces IDLE.
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0.
  - `rsp_data` = 0, `rsp_tag` = 0, `rsp_err` = 0.
  - `fpu_op` = 4'b1111 (FPUOP_IDLE), `fpu_src*` = 0.
  - RR pointer = 0.
- IDLE:
  - `req_ready[i]` = 1 only for the granted requester; the grant is combinational from `req_valid` and the RR pointer.
  - Pointer p gives priority to requester p. If only one requester is valid, it wins.
  - On handshake:
    - Capture op, srcs, tag and requester index.
    - Pointer becomes ~index.
    - Legal op: go to EXEC.
    - Illegal op: set `rsp_err` = 1, `rsp_data` = 0, go straight to RESP with no FPU activity.
- EXEC:
  - `fpu_op`/`fpu_src*` are driven from the capture registers.
  - On `fpu_fin` = 1: register `fpu_result` into `rsp_data` and go to RESP.
  - The FPU's `fin` is combinationally 1 in the first EXEC cycle for ops 0101–1010, so they leave EXEC after 1 cycle.
- RESP:
  - `fpu_op` = FPUOP_IDLE. The FPU counter has already returned to 0 on `fin`.
  - `rsp_valid[idx]` = 1, held with data/tag/err stable until `rsp_ready[idx]`; then go to IDLE.
  - `rsp_ready` of the other requester is ignored.
- Latency: handshake cycle T → `rsp_valid` at T+L+2. L per op:
  - fadd/fsub: 3
  - fmul: 2
  - fdiv: 10
  - fsqrt: 7
  - fcvt: 1
  - sgnj/cmp: 0
- Throughput: one op in flight; a new accept is possible no earlier than the cycle after the response handshake.
- `req_ready` is 0 in EXEC and RESP. Requests arriving then wait; no drop, no reorder per requester.
- Simultaneous valid on both requesters: the pointer decides. Back-to-back contention alternates strictly.
- `rst` mid-EXEC:
  - Abort; no response is generated and the requester must reissue.
  - `fpu_op` returns to idle in the same edge; the FPU is reset via `rstn`.
- `fpu_fin` outside EXEC is ignored.

Optional Feature:
- Macro `FPU_SCHED_PERF_EN`.
- Defined:
  - Adds outputs `perf_ops` [31:0] (count of completed response handshakes, including errors) and `perf_busy` [31:0] (cycles spent in EXEC).
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package `fpu_sched_pkg`:
  - Opcode localparams: FPUOP_FADD = 4'b0000 … FPUOP_FCVTSW = 4'b1100, FPUOP_IDLE = 4'b1111.
  - State enum `sched_state_e` {IDLE, EXEC, RESP}.
  - Function `is_legal_op`.
- Sub-module `rr_arb2`:
  - Two-way round-robin grant with pointer update on accept.
  - Inputs req[1:0] and accept; output gnt[1:0].

Test Plan:
- Req0 fadd 0x3F800000 + 0x40000000, tag 3 → `rsp_valid[0]` at T+5, `rsp_data` 0x40400000, `rsp_tag` 3, `fpu_op` returns to 1111.
- Both valid at reset (req0 fmul, req1 fdiv) → req0 is served first, req1 next; with both held valid, three further ops alternate 0,1,0.
- Req1 feq 0x40000000 vs 0x40000000 → `rsp_data` = 1 at T+2; then fdiv 1.0/4.0 → 0x3E800000 at T+12.
- Req0 op 4'b1110 → `rsp_err` = 1, `rsp_data` 0 at T+1, `fpu_op` stays 1111 throughout.
- `rsp_ready` held 0 for 20 cycles during RESP → data/tag stable, `req_ready` = 2'b00; release → IDLE next cycle.
- Assert `rst` during fsqrt EXEC cycle 4 → next cycle all outputs at reset values and no `rsp_valid`; with `FPU_SCHED_PERF_EN`, counters read 0.
